router_port_arbiter: RTL and testbench
======================================

# router_port_arbiter

Output-port scheduler for the mesh router: shares one terminal output queue among N_IN input queues using the pndng/pop handshake. It filters each input's head packet on its destination field and grants one matching input per cycle in round-robin order. The granted packet is registered into a one-entry output stage that presents pndng/data to the downstream consumer. A watchdog flags an output held longer than TIMEOUT cycles without a pop, mirroring the router's progress requirement.

## Interface
- N_IN, 4: number of input queues (≥2)
- PCK_SZ, 40: packet width in bits
- DST_MSB, 31: destination field MSB
- DST_LSB, 26: destination field LSB (field is 6 bits at defaults)
- PORT_ID, 0: terminal id served by this port; compared against the destination field
- TIMEOUT, 128: watchdog limit in cycles (≥2)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low: reset==0 clears all state immediately
- in_data  in  [N_IN][PCK_SZ]  head packet of each input queue
- in_pndng  in  [N_IN]  input queue i holds a valid head packet
- in_pop  out  [N_IN]  combinational; pops input i in this cycle; at most one bit high
- out_data  out  PCK_SZ  registered output packet
- out_pndng  out  1  output packet valid
- out_pop  in  1  consumer takes out_data this cycle
- last_grant  out  $clog2(N_IN)  index of the most recent grant
- stall  out  1  watchdog flag

## Operation
- req[i] = in_pndng[i] && (in_data[i][DST_MSB:DST_LSB] == PORT_ID). Inputs whose head packet targets another port are never popped.
- State machine on the output stage:
  - EMPTY: out_pndng=0.
  - FULL: out_pndng=1, waiting for out_pop.
  - STALLED: out_pndng=1, stall=1.
- Load condition: load = (|req) && (state==EMPTY || out_pop).
- On load:
  - Winner w is the first i with req[i] set, scanning rr_ptr, rr_ptr+1, … modulo N_IN.
  - in_pop[w]=1 in the same cycle.
  - At the edge: out_data←in_data[w], last_grant←w, rr_ptr←(w+1) mod N_IN.
- Transitions:
  - EMPTY→FULL on load.
  - FULL/STALLED→FULL on out_pop with load (back-to-back; no bubble).
  - FULL/STALLED→EMPTY on out_pop without load.
  - FULL→STALLED when wait_cnt reaches TIMEOUT.
- out_pop while out_pndng=0 is ignored. No packet is popped and none is lost.
- wait_cnt, width $clog2(TIMEOUT+1):
  - Clears to 0 on every load.
  - Increments each cycle in FULL with out_pop=0.
  - Saturates at TIMEOUT.
- stall asserts on entry to STALLED and stays high until the next out_pop. It clears at the edge where out_pop is sampled.
- rr_ptr advances only on a grant. Non-matching or idle inputs do not move it.
- The block never modifies packets. out_data holds its value while FULL/STALLED.

## Timing
- Reset values (asynchronous, reset==0):
  - out_pndng=0, out_data=0, last_grant=0, stall=0.
  - rr_ptr=0, wait_cnt=0, state EMPTY.
  - in_pop forced to all-zero while reset==0.
- Latency: req[i] high at cycle t with the stage empty gives in_pop[i]=1 at t and out_pndng=1 from t+1.
- Throughput: one packet per cycle when out_pop is held high and requests are continuous.
- Fairness: each continuously requesting input is granted within N_IN consecutive grants.
- Watchdog:
  - Packet loaded at edge t0 and out_pop held low → stall=1 from edge t0+TIMEOUT.
  - out_pop at cycle t0+TIMEOUT-1 prevents stall.
- Reset mid-operation: a held output packet is discarded and out_pndng drops asynchronously. Arbitration restarts from index 0 after release.
- in_pop is a function of the current cycle's in_pndng, in_data, state and out_pop only. It has no dependence on downstream combinational paths beyond out_pop.

## Test plan
- Reset, then a single request: in_pndng[2]=1 with dst=PORT_ID → in_pop[2]=1 in that cycle; out_pndng=1 and last_grant=2 next cycle; out_data equals the input packet.
- Destination filter: in_pndng[1]=1 with dst=PORT_ID+1 for 20 cycles → in_pop stays 0 and out_pndng stays 0.
- Round-robin: all 4 inputs request continuously with out_pop=1 → grant order 0,1,2,3,0,1,…; one packet per cycle; no input pops twice for a single packet.
- Backpressure: out_pop=0 while 3 inputs request → exactly one pop, then no pops; stall=1 exactly 128 cycles after the load. A later single out_pop clears stall and loads the next input with no bubble.
- Simultaneous pop and load: stage FULL, out_pop=1 and req[3]=1 in the same cycle → out_data replaced by input 3's packet; out_pndng stays 1 continuously.
- Reset mid-hold: assert reset=0 between clock edges while FULL → out_pndng=0 and in_pop=0 immediately. After release, the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/router_port_arbiter_if.sv
// Handshake bundle between the input queues, the port arbiter and the
// downstream terminal consumer. The master side is the arbiter.
interface router_port_arbiter_if #(
  parameter int N_IN   = 4,
  parameter int PCK_SZ = 40
);
  logic [N_IN-1:0][PCK_SZ-1:0] in_data;
  logic [N_IN-1:0]             in_pndng;
  logic [N_IN-1:0]             in_pop;
  logic [PCK_SZ-1:0]           out_data;
  logic                        out_pndng;
  logic                        out_pop;

  modport master (
    input  in_data, in_pndng, out_pop,
    output in_pop, out_data, out_pndng
  );

  modport slave (
    output in_data, in_pndng, out_pop,
    input  in_pop, out_data, out_pndng
  );
endinterface

// File: rtl/router_port_arbiter.sv
// Output-port scheduler: filters input heads on destination, grants one
// matching input per cycle round-robin into a one-entry output stage, and
// flags a stall when the held packet is not consumed within TIMEOUT cycles.
module router_port_arbiter #(
  parameter int N_IN    = 4,
  parameter int PCK_SZ  = 40,
  parameter int DST_MSB = 31,
  parameter int DST_LSB = 26,
  parameter int PORT_ID = 0,
  parameter int TIMEOUT = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  router_port_arbiter_if.master     bus,
  output logic [$clog2(N_IN)-1:0]   last_grant,
  output logic                      stall
);

  localparam int GW    = $clog2(N_IN);
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam int DST_W = DST_MSB - DST_LSB + 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    STALLED = 2'd2
  } state_t;

  state_t            state_q;
  logic [GW-1:0]     rr_q;
  logic [CW-1:0]     wait_cnt_q;
  logic [PCK_SZ-1:0] out_data_q;
  logic              out_pndng_q;
  logic [GW-1:0]     last_grant_q;
  logic              stall_q;

  logic [N_IN-1:0]   req;
  logic              found;
  logic [GW-1:0]     win_d;
  logic [GW-1:0]     rr_d;
  logic              load;
  logic [N_IN-1:0]   in_pop_d;

  // Destination filter, rotating priority scan from rr_q, and pop strobe.
  always_comb begin
    int unsigned idx;
    req      = '0;
    found    = 1'b0;
    win_d    = '0;
    idx      = 0;
    in_pop_d = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      req[i] = bus.in_pndng[i] &&
               (bus.in_data[i][DST_MSB:DST_LSB] == DST_W'(PORT_ID));
    end
    for (int unsigned k = 0; k < N_IN; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!found && req[idx]) begin
        found = 1'b1;
        win_d = GW'(idx);
      end
    end
    rr_d = (win_d == GW'(N_IN - 1)) ? '0 : win_d + GW'(1);
    load = found && (state_q == EMPTY || bus.out_pop);
    if (load && reset) in_pop_d[win_d] = 1'b1;
  end

  // Output stage FSM with registered outputs and the hold watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      rr_q         <= '0;
      wait_cnt_q   <= '0;
      out_data_q   <= '0;
      out_pndng_q  <= 1'b0;
      last_grant_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      if (load) begin
        state_q      <= FULL;
        out_data_q   <= bus.in_data[win_d];
        out_pndng_q  <= 1'b1;
        last_grant_q <= win_d;
        rr_q         <= rr_d;
        wait_cnt_q   <= '0;
        stall_q      <= 1'b0;
      end else begin
        case (state_q)
          FULL, STALLED: begin
            if (bus.out_pop) begin
              state_q     <= EMPTY;
              out_pndng_q <= 1'b0;
              stall_q     <= 1'b0;
            end else if (state_q == FULL) begin
              // Stall is raised on the same edge the count reaches TIMEOUT.
              if (wait_cnt_q != CW'(TIMEOUT)) wait_cnt_q <= wait_cnt_q + CW'(1);
              if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                state_q <= STALLED;
                stall_q <= 1'b1;
              end
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  assign bus.in_pop    = in_pop_d;
  assign bus.out_data  = out_data_q;
  assign bus.out_pndng = out_pndng_q;
  assign last_grant    = last_grant_q;
  assign stall         = stall_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Self-checking bench for router_port_arbiter: directed scenarios followed
// by randomized traffic compared against a behavioural model.
module tb_router_port_arbiter;
  localparam int N_IN    = 4;
  localparam int PCK_SZ  = 40;
  localparam int DST_MSB = 31;
  localparam int DST_LSB = 26;
  localparam int PORT_ID = 0;
  localparam int TIMEOUT = 128;
  localparam int GW      = $clog2(N_IN);

  logic clk;
  logic reset;
  logic [GW-1:0] last_grant;
  logic stall;
  int checks;
  int failures;

  router_port_arbiter_if #(.N_IN(N_IN), .PCK_SZ(PCK_SZ)) bus ();

  router_port_arbiter #(
    .N_IN(N_IN), .PCK_SZ(PCK_SZ), .DST_MSB(DST_MSB), .DST_LSB(DST_LSB),
    .PORT_ID(PORT_ID), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .last_grant(last_grant), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PCK_SZ-1:0] mkpkt(input int dst);
    logic [PCK_SZ-1:0] p;
    p = PCK_SZ'({$urandom, $urandom});
    p[DST_MSB:DST_LSB] = (DST_MSB - DST_LSB + 1)'(dst);
    return p;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_pndng = '0;
    bus.out_pop  = 1'b0;
    for (int i = 0; i < N_IN; i++) bus.in_data[i] = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic drain();
    bus.in_pndng = '0;
    bus.out_pop  = 1'b1;
    cyc();
    bus.out_pop  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.in_pndng = '1;
    for (int i = 0; i < N_IN; i++) bus.in_data[i] = mkpkt(PORT_ID);
    #3;
    checks++; if (bus.out_pndng !== 1'b0) begin failures++; $display("FAIL reset_out_pndng got %b want 0", bus.out_pndng); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    checks++; if (last_grant !== '0) begin failures++; $display("FAIL reset_last_grant got %0d want 0", last_grant); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (bus.in_pop !== '0) begin failures++; $display("FAIL reset_in_pop got %b want 0", bus.in_pop); end
    cyc();
    checks++; if (bus.out_pndng !== 1'b0) begin failures++; $display("FAIL reset_hold_out_pndng got %b want 0", bus.out_pndng); end
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [PCK_SZ-1:0] p;
    p = mkpkt(PORT_ID);
    bus.in_data[2] = p;
    bus.in_pndng   = 4'b0100;
    #1;
    checks++; if (bus.in_pop !== 4'b0100) begin failures++; $display("FAIL single_in_pop got %b want 0100", bus.in_pop); end
    cyc();
    checks++; if (bus.out_pndng !== 1'b1) begin failures++; $display("FAIL single_out_pndng got %b want 1", bus.out_pndng); end
    checks++; if (last_grant !== 2'd2) begin failures++; $display("FAIL single_last_grant got %0d want 2", last_grant); end
    checks++; if (bus.out_data !== p) begin failures++; $display("FAIL single_out_data got %h want %h", bus.out_data, p); end
    bus.in_pndng = '0;
    bus.out_pop  = 1'b1;
    #1;
    checks++; if (bus.in_pop !== '0) begin failures++; $display("FAIL single_no_repop got %b want 0", bus.in_pop); end
    cyc();
    checks++; if (bus.out_pndng !== 1'b0) begin failures++; $display("FAIL single_empty got %b want 0", bus.out_pndng); end
    bus.out_pop = 1'b0;
  endtask

  task automatic test_filter();
    bus.in_data[1] = mkpkt(PORT_ID + 1);
    bus.in_pndng   = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      bus.out_pop = c[0];
      #1;
      checks++; if (bus.in_pop !== '0) begin failures++; $display("FAIL filter_in_pop c=%0d got %b want 0", c, bus.in_pop); end
      cyc();
      checks++; if (bus.out_pndng !== 1'b0) begin failures++; $display("FAIL filter_out_pndng c=%0d got %b want 0", c, bus.out_pndng); end
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [PCK_SZ-1:0] p;
    pulse_reset();
    bus.out_pop  = 1'b1;
    bus.in_pndng = '1;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N_IN; i++) bus.in_data[i] = mkpkt(PORT_ID);
      p = bus.in_data[t % N_IN];
      #1;
      checks++; if (bus.in_pop !== 4'(1 << (t % N_IN))) begin failures++; $display("FAIL rr_in_pop t=%0d got %b want %b", t, bus.in_pop, 4'(1 << (t % N_IN))); end
      cyc();
      checks++; if (last_grant !== GW'(t % N_IN)) begin failures++; $display("FAIL rr_last_grant t=%0d got %0d want %0d", t, last_grant, t % N_IN); end
      checks++; if (bus.out_data !== p || bus.out_pndng !== 1'b1) begin failures++; $display("FAIL rr_out t=%0d got %h/%b want %h/1", t, bus.out_data, bus.out_pndng, p); end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [PCK_SZ-1:0] p0, p1;
    p0 = mkpkt(PORT_ID);
    p1 = mkpkt(PORT_ID);
    bus.in_data[0] = p0;
    bus.in_data[1] = p1;
    bus.in_data[3] = mkpkt(PORT_ID);
    bus.in_pndng   = 4'b1011;
    bus.out_pop    = 1'b0;
    #1;
    checks++; if (bus.in_pop !== 4'b0001) begin failures++; $display("FAIL bp_first_pop got %b want 0001", bus.in_pop); end
    cyc();
    for (int k = 1; k <= TIMEOUT; k++) begin
      checks++; if (bus.in_pop !== '0) begin failures++; $display("FAIL bp_hold_pop k=%0d got %b want 0", k, bus.in_pop); end
      cyc();
      checks++; if (stall !== (k == TIMEOUT)) begin failures++; $display("FAIL bp_stall k=%0d got %b want %b", k, stall, k == TIMEOUT); end
    end
    checks++; if (bus.out_data !== p0 || bus.out_pndng !== 1'b1) begin failures++; $display("FAIL bp_held got %h/%b want %h/1", bus.out_data, bus.out_pndng, p0); end
    bus.out_pop = 1'b1;
    #1;
    checks++; if (bus.in_pop !== 4'b0010) begin failures++; $display("FAIL bp_release_pop got %b want 0010", bus.in_pop); end
    cyc();
    bus.out_pop = 1'b0;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL bp_stall_clear got %b want 0", stall); end
    checks++; if (bus.out_pndng !== 1'b1 || last_grant !== 2'd1 || bus.out_data !== p1) begin failures++; $display("FAIL bp_next_load got %b/%0d/%h want 1/1/%h", bus.out_pndng, last_grant, bus.out_data, p1); end
    drain();
  endtask

  task automatic test_pop_load();
    logic [PCK_SZ-1:0] p3;
    bus.in_data[0] = mkpkt(PORT_ID);
    bus.in_pndng   = 4'b0001;
    cyc();
    p3 = mkpkt(PORT_ID);
    bus.in_data[3] = p3;
    bus.in_pndng   = 4'b1000;
    bus.out_pop    = 1'b1;
    #1;
    checks++; if (bus.in_pop !== 4'b1000) begin failures++; $display("FAIL popload_in_pop got %b want 1000", bus.in_pop); end
    checks++; if (bus.out_pndng !== 1'b1) begin failures++; $display("FAIL popload_full_before got %b want 1", bus.out_pndng); end
    cyc();
    checks++; if (bus.out_pndng !== 1'b1 || bus.out_data !== p3 || last_grant !== 2'd3) begin failures++; $display("FAIL popload_after got %b/%h/%0d want 1/%h/3", bus.out_pndng, bus.out_data, last_grant, p3); end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.in_data[2] = mkpkt(PORT_ID);
    bus.in_pndng   = 4'b0100;
    cyc();
    for (int i = 0; i < N_IN; i++) bus.in_data[i] = mkpkt(PORT_ID);
    bus.in_pndng = 4'b1110;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.out_pndng !== 1'b0) begin failures++; $display("FAIL midrst_out_pndng got %b want 0", bus.out_pndng); end
    checks++; if (bus.in_pop !== '0) begin failures++; $display("FAIL midrst_in_pop got %b want 0", bus.in_pop); end
    cyc();
    reset = 1'b1;
    #1;
    checks++; if (bus.in_pop !== 4'b0010) begin failures++; $display("FAIL midrst_first_grant got %b want 0010", bus.in_pop); end
    cyc();
    checks++; if (last_grant !== 2'd1 || bus.out_pndng !== 1'b1) begin failures++; $display("FAIL midrst_last_grant got %0d/%b want 1/1", last_grant, bus.out_pndng); end
    drain();
  endtask

  // Randomized traffic against a model of the scheduling rules.
  task automatic test_random();
    logic              m_valid, m_stall;
    logic [PCK_SZ-1:0] m_data;
    int                m_lg, m_rr, m_age;
    logic [N_IN-1:0]   mreq, exp_pop;
    int                w, best, mode;
    logic              load;
    pulse_reset();
    idle_inputs();
    m_valid = 0; m_stall = 0; m_data = '0; m_lg = 0; m_rr = 0; m_age = 0;
    mode = 1;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) mode = $urandom_range(0, 3);
      for (int i = 0; i < N_IN; i++)
        bus.in_data[i] = mkpkt(($urandom_range(0, 3) == 0) ? PORT_ID + 1 + $urandom_range(0, 2) : PORT_ID);
      bus.in_pndng = N_IN'($urandom);
      bus.out_pop  = (mode == 0) ? 1'b0 : ($urandom_range(1, mode) == 1);
      #1;
      // Winner: requesting input with the smallest forward distance from rr.
      w = -1; best = N_IN;
      for (int i = 0; i < N_IN; i++) begin
        mreq[i] = bus.in_pndng[i] && (bus.in_data[i][DST_MSB:DST_LSB] == (DST_MSB - DST_LSB + 1)'(PORT_ID));
        if (mreq[i] && ((i - m_rr + N_IN) % N_IN) < best) begin
          best = (i - m_rr + N_IN) % N_IN;
          w = i;
        end
      end
      load = (w >= 0) && (!m_valid || bus.out_pop);
      exp_pop = load ? N_IN'(1 << w) : '0;
      checks++; if (bus.in_pop !== exp_pop) begin failures++; $display("FAIL rand_in_pop c=%0d got %b want %b", c, bus.in_pop, exp_pop); end
      if (load) begin
        m_data = bus.in_data[w]; m_lg = w; m_rr = (w + 1) % N_IN;
        m_valid = 1; m_age = 0; m_stall = 0;
      end else if (m_valid && bus.out_pop) begin
        m_valid = 0; m_stall = 0;
      end else if (m_valid) begin
        m_age++;
        if (m_age >= TIMEOUT) m_stall = 1;
      end
      cyc();
      checks++; if (bus.out_pndng !== m_valid) begin failures++; $display("FAIL rand_out_pndng c=%0d got %b want %b", c, bus.out_pndng, m_valid); end
      checks++; if (stall !== m_stall) begin failures++; $display("FAIL rand_stall c=%0d got %b want %b", c, stall, m_stall); end
      checks++; if (last_grant !== GW'(m_lg)) begin failures++; $display("FAIL rand_last_grant c=%0d got %0d want %0d", c, last_grant, m_lg); end
      if (m_valid) begin
        checks++; if (bus.out_data !== m_data) begin failures++; $display("FAIL rand_out_data c=%0d got %h want %h", c, bus.out_data, m_data); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_filter();
    test_round_robin();
    test_backpressure();
    test_pop_load();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
